line_buf_bank_sched: RTL and testbench
======================================

// Module: line_buf_bank_sched
// PURPOSE
//  Sequences an NBANK-deep rotating bank of single-line SRAMs for vertical-window filters.
//  Each active line is written into one bank while the NBANK-1 previously stored lines are read at the same address.
//  At frame end it runs one self-timed flush read pass.
//  Sits between the sync/DE input timing and the line SRAMs; the pixel datapath follows its strobes.
// PARAMETERS
//  HACT   10                 active pixels per line
//  VACT   4                  active lines per frame; must be >= NBANK-1
//  NBANK  3                  number of line SRAM banks (>=2)
//  AW     $clog2(HACT)       SRAM address width (derived)
//  BW     $clog2(NBANK)      bank index width (derived)
// PORTS
//  clk         in   1       pixel clock, all logic on rising edge
//  rstn        in   1       synchronous reset, active-low
//  i_vsync     in   1       vertical sync, active high; rising edge starts a frame
//  i_hsync     in   1       horizontal sync, active high
//  i_de        in   1       input data enable
//  o_ram_we    out  NBANK   one-hot write enable, per bank
//  o_ram_re    out  NBANK   read enable, per bank
//  o_ram_addr  out  AW      shared write/read address for all banks
//  o_wr_bank   out  BW      index of the bank currently being written (tap-ordering for datapath)
//  o_rd_valid  out  1       SRAM read data valid (o_ram_re OR-reduced, delayed 1 clk)
//  o_flush     out  1       high during flush read pass
//  o_line_cnt  out  $clog2(VACT+1)  completed lines in current frame
//  o_state     out  2       FSM state
// BEHAVIOUR
//  - Reset (rstn=0 at clk edge): all outputs 0, state ST_IDLE, wr_bank 0; dominates all other inputs.
//  - All outputs registered; o_ram_we/re/addr appear 1 clk after the i_de sample that causes them.
//    The datapath delays pixel data by 1 clk to align.
//  - o_rd_valid = |o_ram_re delayed 1 clk (SRAM read latency 1).
//  - Edges are detected on registered copies of the inputs.
//    Line end = i_de falling edge; vsync event = i_vsync rising edge.
//  - FSM states:
//    - ST_IDLE(0): i_de ignored. vsync event -> ST_FILL.
//    - ST_FILL(1): while i_de=1, we=onehot(wr_bank), re=0.
//      At line end: line_cnt++, wr_bank=(wr_bank+1)%NBANK.
//      -> ST_RUN once line_cnt reaches NBANK-1.
//    - ST_RUN(2): while i_de=1, we=onehot(wr_bank), re=~onehot(wr_bank).
//      At line end: line_cnt++, wr_bank rotates.
//      -> ST_FLUSH once line_cnt reaches VACT.
//    - ST_FLUSH(3): i_de ignored; waits for i_hsync rising edge.
//      Then HACT clks with we=0, re=~onehot(wr_bank), o_flush=1, addr 0..HACT-1.
//      After that pass -> ST_IDLE.
//  - Address:
//    - o_ram_addr returns to 0 at each line end and at each vsync event.
//    - Increments by 1 on every clk with any we/re asserted.
//    - At HACT-1 it holds; any further i_de cycles of that line give we=0, re=0 (excess pixels dropped).
//  - Short line (i_de shorter than HACT): line still counts; unwritten addresses keep stale data.
//  - vsync event in any non-IDLE state (incl. mid-line, mid-flush) aborts:
//    - next clk we=0, re=0, o_flush=0;
//    - addr=0, line_cnt=0, wr_bank=0;
//    - state ST_FILL.
//  - vsync event coinciding with line end: vsync wins, line not counted.
//  - o_line_cnt saturates at VACT; wr_bank wraps NBANK-1 -> 0.
// TESTING  (HACT=10, VACT=4, NBANK=3)
//  1. Idle: reset, then 12-clk i_de pulse before any vsync
//     -> we=000, re=000, o_state=0, addr=0.
//  2. Fill: vsync, then two 10-clk DE lines
//     -> we=001 then 010, addr 0..9, re=000.
//     -> o_line_cnt 1 then 2; o_state=2 after the 2nd DE falls.
//  3. Run: lines 3,4
//     -> line3 we=100 re=011; line4 we=001 re=110.
//     -> o_rd_valid follows re by 1 clk for 10 clks; o_state=3 after line4.
//  4. Flush: hsync rise in ST_FLUSH (wr_bank=1)
//     -> re=101, we=000, o_flush=1 for 10 clks, addr 0..9; then o_state=0.
//  5. Overlong line: 13-clk DE in ST_RUN
//     -> we/re high for exactly 10 clks, addr holds 9, line_cnt +1.
//  6. Abort: vsync rise at pixel 5 of line 3; separately rstn=0 mid-line
//     -> next clk we=re=000, addr=0, line_cnt=0, wr_bank=0.
//     -> o_state=1 (vsync case) / 0 (reset case).

Source files
------------

// File: rtl/line_buf_bank_sched.sv
// Rotating line-SRAM bank sequencer for vertical-window filters.
// Writes the live line into one bank, reads the others, then flushes at frame end.
module line_buf_bank_sched #(
  parameter int HACT  = 10,
  parameter int VACT  = 4,
  parameter int NBANK = 3,
  parameter int AW    = $clog2(HACT),
  parameter int BW    = $clog2(NBANK),
  parameter int CW    = $clog2(VACT+1)
)(
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_vsync,
  input  logic             i_hsync,
  input  logic             i_de,
  output logic [NBANK-1:0] o_ram_we,
  output logic [NBANK-1:0] o_ram_re,
  output logic [AW-1:0]    o_ram_addr,
  output logic [BW-1:0]    o_wr_bank,
  output logic             o_rd_valid,
  output logic             o_flush,
  output logic [CW-1:0]    o_line_cnt,
  output logic [1:0]       o_state
);

  localparam int PW = $clog2(HACT+1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } st_e;

  st_e             st_q, st_d;
  logic [BW-1:0]   bank_q, bank_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pix_q, pix_d;
  logic            fact_q, fact_d;
  logic [NBANK-1:0] we_q, we_d;
  logic [NBANK-1:0] re_q, re_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            fl_q, fl_d;
  logic            rv_q;
  logic            vs_q, hs_q, de_q;

  logic            vs_ev, hs_ev, line_end;
  logic [NBANK-1:0] oh;
  logic [CW-1:0]   cnt_inc;
  logic [BW-1:0]   bank_nx;

  assign vs_ev    = i_vsync & ~vs_q;
  assign hs_ev    = i_hsync & ~hs_q;
  assign line_end = de_q & ~i_de;
  assign oh       = NBANK'(1) << bank_q;
  assign cnt_inc  = (cnt_q >= CW'(VACT)) ? cnt_q : cnt_q + 1'b1;
  assign bank_nx  = (bank_q == BW'(NBANK-1)) ? '0 : bank_q + 1'b1;

  always_comb begin
    st_d   = st_q;
    bank_d = bank_q;
    cnt_d  = cnt_q;
    pix_d  = pix_q;
    fact_d = fact_q;
    addr_d = addr_q;
    we_d   = '0;
    re_d   = '0;
    fl_d   = 1'b0;
    if (vs_ev) begin
      // a new frame always restarts sequencing, even mid-line or mid-flush
      st_d   = ST_FILL;
      bank_d = '0;
      cnt_d  = '0;
      pix_d  = '0;
      fact_d = 1'b0;
      addr_d = '0;
    end else begin
      unique case (st_q)
        ST_IDLE: begin
        end
        ST_FILL, ST_RUN: begin
          if (line_end) begin
            cnt_d  = cnt_inc;
            bank_d = bank_nx;
            pix_d  = '0;
            addr_d = '0;
            if (cnt_inc >= CW'(VACT))
              st_d = ST_FLUSH;
            else if (st_q == ST_FILL && cnt_inc == CW'(NBANK-1))
              st_d = ST_RUN;
          end else if (i_de && pix_q < PW'(HACT)) begin
            we_d   = oh;
            re_d   = (st_q == ST_RUN) ? ~oh : '0;
            addr_d = AW'(pix_q);
            pix_d  = pix_q + 1'b1;
          end
        end
        ST_FLUSH: begin
          if (fact_q) begin
            if (pix_q < PW'(HACT)) begin
              re_d   = ~oh;
              fl_d   = 1'b1;
              addr_d = AW'(pix_q);
              pix_d  = pix_q + 1'b1;
            end else begin
              fact_d = 1'b0;
              pix_d  = '0;
              addr_d = '0;
              st_d   = ST_IDLE;
            end
          end else if (hs_ev) begin
            fact_d = 1'b1;
            re_d   = ~oh;
            fl_d   = 1'b1;
            addr_d = '0;
            pix_d  = PW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q   <= ST_IDLE;
      bank_q <= '0;
      cnt_q  <= '0;
      pix_q  <= '0;
      fact_q <= 1'b0;
      we_q   <= '0;
      re_q   <= '0;
      addr_q <= '0;
      fl_q   <= 1'b0;
      rv_q   <= 1'b0;
      vs_q   <= 1'b0;
      hs_q   <= 1'b0;
      de_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      bank_q <= bank_d;
      cnt_q  <= cnt_d;
      pix_q  <= pix_d;
      fact_q <= fact_d;
      we_q   <= we_d;
      re_q   <= re_d;
      addr_q <= addr_d;
      fl_q   <= fl_d;
      rv_q   <= |re_q;
      vs_q   <= i_vsync;
      hs_q   <= i_hsync;
      de_q   <= i_de;
    end
  end

  assign o_ram_we   = we_q;
  assign o_ram_re   = re_q;
  assign o_ram_addr = addr_q;
  assign o_wr_bank  = bank_q;
  assign o_rd_valid = rv_q;
  assign o_flush    = fl_q;
  assign o_line_cnt = cnt_q;
  assign o_state    = st_q;

endmodule

// File: tb/tb_line_buf_bank_sched.sv
// Directed bench for line_buf_bank_sched with a per-cycle frame model.
// Literal checks pin the model; the compare process checks every cycle.
module tb_line_buf_bank_sched;

  localparam int HACT = 10;
  localparam int VACT = 4;
  localparam int NB   = 3;
  localparam int ALL  = (1 << NB) - 1;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       i_vsync = 1'b0;
  logic       i_hsync = 1'b0;
  logic       i_de = 1'b0;
  logic [2:0] o_ram_we;
  logic [2:0] o_ram_re;
  logic [3:0] o_ram_addr;
  logic [1:0] o_wr_bank;
  logic       o_rd_valid;
  logic       o_flush;
  logic [2:0] o_line_cnt;
  logic [1:0] o_state;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  line_buf_bank_sched #(.HACT(HACT), .VACT(VACT), .NBANK(NB)) dut (
    .clk(clk), .rstn(rstn),
    .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de),
    .o_ram_we(o_ram_we), .o_ram_re(o_ram_re),
    .o_ram_addr(o_ram_addr), .o_wr_bank(o_wr_bank),
    .o_rd_valid(o_rd_valid), .o_flush(o_flush),
    .o_line_cnt(o_line_cnt), .o_state(o_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // frame model: state, bank, line count, pixel position
  int m_st, m_bank, m_cnt, m_pix, m_addr;
  bit m_fact, m_pv, m_ph, m_pd;
  int e_we, e_re, e_fl, e_rv;

  always @(posedge clk) begin
    bit vev, hev, lend;
    int we, re, fl;
    vev = i_vsync && !m_pv;
    hev = i_hsync && !m_ph;
    lend = m_pd && !i_de;
    we = 0; re = 0; fl = 0;
    if (!rstn) begin
      m_st = 0; m_bank = 0; m_cnt = 0; m_pix = 0; m_addr = 0;
      m_fact = 0; m_pv = 0; m_ph = 0; m_pd = 0;
      e_we = 0; e_re = 0; e_fl = 0; e_rv = 0;
    end else begin
      e_rv = (e_re != 0);
      if (vev) begin
        m_st = 1; m_bank = 0; m_cnt = 0; m_pix = 0;
        m_addr = 0; m_fact = 0;
      end else if (m_st == 1 || m_st == 2) begin
        if (lend) begin
          m_cnt = (m_cnt < VACT) ? m_cnt + 1 : VACT;
          m_bank = (m_bank + 1) % NB;
          m_pix = 0; m_addr = 0;
          if (m_cnt >= VACT) m_st = 3;
          else if (m_cnt >= NB - 1) m_st = 2;
        end else if (i_de && m_pix < HACT) begin
          we = 1 << m_bank;
          re = (m_st == 2) ? (ALL ^ we) : 0;
          m_addr = m_pix;
          m_pix++;
        end
      end else if (m_st == 3) begin
        if (!m_fact && hev) begin
          m_fact = 1; m_pix = 0;
        end
        if (m_fact) begin
          if (m_pix < HACT) begin
            re = ALL ^ (1 << m_bank); fl = 1;
            m_addr = m_pix; m_pix++;
          end else begin
            m_fact = 0; m_pix = 0; m_addr = 0; m_st = 0;
          end
        end
      end
      e_we = we; e_re = re; e_fl = fl;
      m_pv = i_vsync; m_ph = i_hsync; m_pd = i_de;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("we", int'(o_ram_we), e_we);
      chk("re", int'(o_ram_re), e_re);
      chk("addr", int'(o_ram_addr), m_addr);
      chk("bank", int'(o_wr_bank), m_bank);
      chk("rd_valid", int'(o_rd_valid), e_rv);
      chk("flush", int'(o_flush), e_fl);
      chk("line_cnt", int'(o_line_cnt), m_cnt);
      chk("state", int'(o_state), m_st);
    end
  end

  task automatic step(input logic vs, input logic hs, input logic de);
    i_vsync = vs; i_hsync = hs; i_de = de;
    @(posedge clk); #1;
  endtask

  task automatic line(input int n, input int ewe, input int ere,
                      input int ecnt, input int est);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 1);
      if (i < HACT) begin
        chk("L_we", int'(o_ram_we), ewe);
        chk("L_re", int'(o_ram_re), ere);
        chk("L_addr", int'(o_ram_addr), i);
        if (i >= 1) chk("L_rv", int'(o_rd_valid), int'(ere != 0));
      end else begin
        chk("L_we_drop", int'(o_ram_we), 0);
        chk("L_re_drop", int'(o_ram_re), 0);
        chk("L_addr_hold", int'(o_ram_addr), HACT - 1);
        if (i == HACT) chk("L_rv", int'(o_rd_valid), int'(ere != 0));
      end
    end
    step(0, 0, 0);
    chk("L_cnt", int'(o_line_cnt), ecnt);
    chk("L_state", int'(o_state), est);
    chk("L_addr0", int'(o_ram_addr), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
  endtask

  task automatic frame_start();
    step(1, 0, 0);
    chk("V_state", int'(o_state), 1);
    step(0, 0, 0);
    step(0, 0, 0);
  endtask

  initial begin
    step(0, 0, 0);
    chk_on = 1'b1;
    step(0, 0, 0);
    chk("R_we", int'(o_ram_we), 0);
    chk("R_state", int'(o_state), 0);
    chk("R_cnt", int'(o_line_cnt), 0);
    rstn = 1'b1;
    step(0, 0, 0);

    // idle: DE before any vsync is ignored
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 1);
      chk("I_we", int'(o_ram_we), 0);
      chk("I_addr", int'(o_ram_addr), 0);
    end
    step(0, 0, 0);
    chk("I_state", int'(o_state), 0);

    // full frame: fill, run, flush
    frame_start();
    line(10, 1, 0, 1, 1);
    line(10, 2, 0, 2, 2);
    line(10, 4, 3, 3, 2);
    line(10, 1, 6, 4, 3);
    chk("F_bank", int'(o_wr_bank), 1);
    for (int i = 0; i < HACT; i++) begin
      step(0, i == 0, 0);
      chk("F_re", int'(o_ram_re), 5);
      chk("F_we", int'(o_ram_we), 0);
      chk("F_flush", int'(o_flush), 1);
      chk("F_addr", int'(o_ram_addr), i);
    end
    step(0, 0, 0);
    chk("F_state", int'(o_state), 0);
    chk("F_flush0", int'(o_flush), 0);
    step(0, 0, 0);

    // overlong line in run
    frame_start();
    line(10, 1, 0, 1, 1);
    line(10, 2, 0, 2, 2);
    line(13, 4, 3, 3, 2);

    // vsync mid-line while DE stays high one more clk
    frame_start();
    line(10, 1, 0, 1, 1);
    line(10, 2, 0, 2, 2);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    step(1, 0, 1);
    chk("A_we", int'(o_ram_we), 0);
    chk("A_re", int'(o_ram_re), 0);
    chk("A_addr", int'(o_ram_addr), 0);
    chk("A_cnt", int'(o_line_cnt), 0);
    chk("A_bank", int'(o_wr_bank), 0);
    chk("A_state", int'(o_state), 1);
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);

    // vsync coinciding with line end: line not counted
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    step(1, 0, 0);
    chk("C_cnt", int'(o_line_cnt), 0);
    chk("C_bank", int'(o_wr_bank), 0);
    chk("C_state", int'(o_state), 1);
    step(0, 0, 0);
    step(0, 0, 0);

    // reset mid-line
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    rstn = 1'b0;
    step(0, 0, 1);
    chk("Z_we", int'(o_ram_we), 0);
    chk("Z_addr", int'(o_ram_addr), 0);
    chk("Z_state", int'(o_state), 0);
    chk("Z_cnt", int'(o_line_cnt), 0);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
